// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, qualifies lock, then releases the system reset.
// Define PLL_RELOCK_CNT_EN to build the saturating relock_count register; otherwise it is tied to 0.
module pll_reset_sequencer #(
   parameter int PLL_RST_CYCLES      = 12,
   parameter int LOCK_STABLE_CYCLES  = 1200,
   parameter int LOCK_TIMEOUT_CYCLES = 120000
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       locked,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       ready,
   output logic [7:0] relock_count,
   output logic       timeout_err,
   output logic [1:0] state_dbg
);

   localparam int CW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] HOLD_LAST    = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
   // The lk_s=1 sample that moves WAIT_LOCK into STABLE is the first good cycle,
   // so STABLE needs LOCK_STABLE_CYCLES-1 more (LOCK_STABLE_CYCLES must be >= 2).
   localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 2);

   typedef enum logic [1:0] {
      HOLD_PLL  = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          lk_meta, lk_s;
   logic          timeout_hit;
   logic          lock_lost;

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         lk_meta <= 1'b0;
         lk_s    <= 1'b0;
      end else begin
         lk_meta <= locked;
         lk_s    <= lk_meta;
      end
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state <= HOLD_PLL;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt + CW'(1);
      timeout_hit = 1'b0;
      lock_lost   = 1'b0;
      case (state)
         HOLD_PLL: begin
            if (cnt == HOLD_LAST) state_n = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            // Lock arriving on the timeout cycle takes priority over the retry.
            if (lk_s) begin
               state_n = STABLE;
            end else if (cnt == TIMEOUT_LAST) begin
               state_n     = HOLD_PLL;
               timeout_hit = 1'b1;
            end
         end
         STABLE: begin
            if (!lk_s) state_n = WAIT_LOCK;
            else if (cnt == STABLE_LAST) state_n = RUN;
         end
         RUN: begin
            cnt_n = cnt;
            if (!lk_s) begin
               state_n   = HOLD_PLL;
               lock_lost = 1'b1;
            end
         end
         default: state_n = HOLD_PLL;
      endcase
      if (state_n != state) cnt_n = '0;
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         pll_rst     <= 1'b1;
         sys_rst     <= 1'b1;
         ready       <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         pll_rst <= (state_n == HOLD_PLL);
         sys_rst <= (state_n != RUN);
         ready   <= (state_n == RUN);
         if (timeout_hit) timeout_err <= 1'b1;
      end
   end

`ifdef PLL_RELOCK_CNT_EN
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         relock_count <= 8'd0;
      end else if (lock_lost && (relock_count != 8'd255)) begin
         relock_count <= relock_count + 8'd1;
      end
   end
`else
   assign relock_count = 8'd0;
`endif

   assign state_dbg = state;

endmodule
